dvi_tmds_encoder: RTL

- Per-channel DVI 1.0 TMDS 8b/10b encoder running in the pixel clock domain. It converts 8-bit pixel data plus two control bits into DC-balanced 10-bit symbols.
- Sits directly upstream of the 4-lane 10:1 DDR serialiser. Three instances (blue/c0=hsync,c1=vsync; green; red) feed its data lanes; the fourth lane carries the constant clock pattern 10'b0000011111.
- dout[0] is the first bit on the wire.

---
 rtl/dvi_tmds_pkg.sv | 77 +++++++
 rtl/dvi_tmds_encoder_if.sv | 25 ++
 rtl/dvi_tmds_encoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dvi_tmds_pkg.sv
// ============================================================================
// dvi_tmds_pkg : shared constants, stage types and helpers for the TMDS encoder
// (TERC4 table used only when TMDS_TERC4_EN is defined). Revision: 1.0
// ============================================================================
`default_nettype none

package dvi_tmds_pkg;

  localparam int         CNT_W_DEFAULT    = 5;
  localparam logic [9:0] CTRL_TOKEN_00    = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01    = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10    = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11    = 10'b1010101011;
  localparam logic [9:0] CLK_LANE_PATTERN = 10'b0000011111;

  typedef struct packed {
    logic       de;
    logic [1:0] ctl;
    logic [7:0] data;
    logic [3:0] n1;
  } s1_t;

  typedef struct packed {
    logic       de;
    logic [1:0] ctl;
    logic [8:0] qm;
    logic [3:0] n1;
    logic [3:0] n0;
  } s2_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

  // HDMI 1.4 TERC4 code table, indexed by the 4-bit auxiliary nibble.
  function automatic logic [9:0] terc4(input logic [3:0] a);
    logic [9:0] t;
    case (a)
      4'h0:    t = 10'b1010011100;
      4'h1:    t = 10'b1001100011;
      4'h2:    t = 10'b1011100100;
      4'h3:    t = 10'b1011100010;
      4'h4:    t = 10'b0101110001;
      4'h5:    t = 10'b0100011110;
      4'h6:    t = 10'b0110001110;
      4'h7:    t = 10'b0100111100;
      4'h8:    t = 10'b1011001100;
      4'h9:    t = 10'b0100111001;
      4'hA:    t = 10'b0110011100;
      4'hB:    t = 10'b1011000110;
      4'hC:    t = 10'b1010001110;
      4'hD:    t = 10'b1001110001;
      4'hE:    t = 10'b0101100011;
      default: t = 10'b1011000011;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dvi_tmds_encoder_if.sv
// ============================================================================
// dvi_tmds_encoder_if : pixel/control input bundle and encoded symbol output;
// island/aux members exist only when TMDS_TERC4_EN is defined. Revision: 1.0
// ============================================================================
`default_nettype none

interface dvi_tmds_encoder_if;
  logic       de;
  logic       c0;
  logic       c1;
  logic [7:0] din;
  logic [9:0] dout;
`ifdef TMDS_TERC4_EN
  logic       island;
  logic [3:0] aux;

  modport master (output de, c0, c1, din, island, aux, input dout);
  modport slave  (input de, c0, c1, din, island, aux, output dout);
`else
  modport master (output de, c0, c1, din, input dout);
  modport slave  (input de, c0, c1, din, output dout);
`endif
endinterface

`default_nettype wire

// File: rtl/dvi_tmds_encoder.sv
// ============================================================================
// dvi_tmds_encoder : 3-stage DVI TMDS 8b/10b channel encoder with running
// disparity; TMDS_TERC4_EN adds TERC4 data-island symbols. Revision: 1.0
// ============================================================================
`default_nettype none

module dvi_tmds_encoder
  import dvi_tmds_pkg::*;
#(
  parameter logic [9:0] RST_SYMBOL = CTRL_TOKEN_00,
  parameter int         CNT_W      = CNT_W_DEFAULT
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  dvi_tmds_encoder_if.slave   bus
);

  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  s1_t s1;
  s2_t s2;
  logic                    use_xnor;
  logic                    acc;
  logic [8:0]              qm;
  logic [3:0]              qm_n1;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] n1s;
  logic signed [CNT_W-1:0] n0s;
  logic signed [CNT_W-1:0] diff;
  logic                    cnt_pos;
  logic                    cnt_neg;
  logic [9:0]              data_sym;
  logic signed [CNT_W-1:0] data_cnt;
  logic [9:0]              sym_next;
  logic signed [CNT_W-1:0] cnt_next;
  logic [9:0]              sym;

`ifdef TMDS_TERC4_EN
  logic       s1_island;
  logic [3:0] s1_aux;
  logic       s2_island;
  logic [3:0] s2_aux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_island <= 1'b0;
      s1_aux    <= '0;
      s2_island <= 1'b0;
      s2_aux    <= '0;
    end else begin
      s1_island <= bus.island;
      s1_aux    <= bus.aux;
      s2_island <= s1_island;
      s2_aux    <= s1_aux;
    end
  end
`endif

  // S1: capture inputs and the data ones-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.de   <= bus.de;
      s1.ctl  <= {bus.c1, bus.c0};
      s1.data <= bus.din;
      s1.n1   <= popcount8(bus.din);
    end
  end

  // S2: transition-minimising chain, XNOR chosen to cut transitions on dense words.
  always_comb begin
    use_xnor = (s1.n1 > 4'd4) || ((s1.n1 == 4'd4) && !s1.data[0]);
    acc      = s1.data[0];
    qm       = '0;
    qm[0]    = acc;
    for (int i = 1; i < 8; i++) begin
      acc   = use_xnor ? ~(acc ^ s1.data[i]) : (acc ^ s1.data[i]);
      qm[i] = acc;
    end
    qm[8] = ~use_xnor;
  end

  assign qm_n1 = popcount8(qm[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else begin
      s2.de  <= s1.de;
      s2.ctl <= s1.ctl;
      s2.qm  <= qm;
      s2.n1  <= qm_n1;
      s2.n0  <= 4'd8 - qm_n1;
    end
  end

  // S3: DC balancing against the running disparity.
  assign n1s     = $signed(CNT_W'(s2.n1));
  assign n0s     = $signed(CNT_W'(s2.n0));
  assign diff    = n1s - n0s;
  assign cnt_neg = cnt[CNT_W-1];
  assign cnt_pos = !cnt[CNT_W-1] && (cnt != '0);

  always_comb begin
    data_sym = '0;
    data_cnt = cnt;
    if ((cnt == '0) || (s2.n1 == s2.n0)) begin
      data_sym = {~s2.qm[8], s2.qm[8], s2.qm[8] ? s2.qm[7:0] : ~s2.qm[7:0]};
      data_cnt = s2.qm[8] ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && (s2.n1 > s2.n0)) || (cnt_neg && (s2.n0 > s2.n1))) begin
      data_sym = {1'b1, s2.qm[8], ~s2.qm[7:0]};
      data_cnt = cnt - diff + (s2.qm[8] ? TWO : '0);
    end else begin
      data_sym = {1'b0, s2.qm[8], s2.qm[7:0]};
      data_cnt = cnt + diff - (s2.qm[8] ? '0 : TWO);
    end
  end

  always_comb begin
    sym_next = ctrl_token(s2.ctl);
    cnt_next = '0;
    if (s2.de) begin
      sym_next = data_sym;
      cnt_next = data_cnt;
    end
`ifdef TMDS_TERC4_EN
    if (s2_island) begin
      sym_next = terc4(s2_aux);
      cnt_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym <= RST_SYMBOL;
      cnt <= '0;
    end else begin
      sym <= sym_next;
      cnt <= cnt_next;
    end
  end

  assign bus.dout = sym;

endmodule

`default_nettype wire
